// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, centre-samples each bit and reassembles
// the byte LSB-first, reporting a clean byte or a framing error as one-cycle pulses.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [31:0] BIT_CYC  = 32'(CLK_FREQ / BAUD_RATE);
  localparam logic [31:0] HALF_CYC = BIT_CYC / 32'd2;
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        rx_p0, rx_p1, rx_p2;
  logic [31:0] cnt_cyc, cnt_cyc_nxt;
  logic [3:0]  cnt_bit, cnt_bit_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  rx_data_nxt;
  logic        rx_valid_nxt, rx_frame_err_nxt;
  logic        start_edge;

  // rx_p0/rx_p1 form the synchroniser; rx_p2 is the history flop for edge detection
  assign start_edge = !rx_p1 && rx_p2;
  assign rx_busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_p0        <= 1'b1;
      rx_p1        <= 1'b1;
      rx_p2        <= 1'b1;
      state        <= ST_IDLE;
      cnt_cyc      <= '0;
      cnt_bit      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_p0        <= rx;
      rx_p1        <= rx_p0;
      rx_p2        <= rx_p1;
      state        <= state_nxt;
      cnt_cyc      <= cnt_cyc_nxt;
      cnt_bit      <= cnt_bit_nxt;
      shift        <= shift_nxt;
      rx_data      <= rx_data_nxt;
      rx_valid     <= rx_valid_nxt;
      rx_frame_err <= rx_frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_cyc_nxt      = cnt_cyc;
    cnt_bit_nxt      = cnt_bit;
    shift_nxt        = shift;
    rx_data_nxt      = rx_data;
    rx_valid_nxt     = 1'b0;
    rx_frame_err_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_cyc_nxt = '0;
        cnt_bit_nxt = '0;
        shift_nxt   = '0;
        if (start_edge) state_nxt = ST_START;
      end
      ST_START: begin
        if (cnt_cyc == HALF_CYC - 32'd1) begin
          cnt_cyc_nxt = '0;
          // a line that is high again at mid-start was a glitch
          state_nxt   = rx_p1 ? ST_IDLE : ST_DATA;
        end else begin
          cnt_cyc_nxt = cnt_cyc + 32'd1;
        end
      end
      ST_DATA: begin
        if (cnt_cyc == BIT_CYC - 32'd1) begin
          cnt_cyc_nxt               = '0;
          shift_nxt[cnt_bit[2:0]]   = rx_p1;
          cnt_bit_nxt               = cnt_bit + 4'd1;
          if (cnt_bit == LAST_BIT) state_nxt = ST_STOP;
        end else begin
          cnt_cyc_nxt = cnt_cyc + 32'd1;
        end
      end
      ST_STOP: begin
        if (cnt_cyc == BIT_CYC - 32'd1) begin
          cnt_cyc_nxt = '0;
          cnt_bit_nxt = '0;
          if (rx_p1) begin
            rx_data_nxt  = shift;
            rx_valid_nxt = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            rx_frame_err_nxt = 1'b1;
            state_nxt        = ST_BREAK;
          end
        end else begin
          cnt_cyc_nxt = cnt_cyc + 32'd1;
        end
      end
      ST_BREAK: begin
        // hold off until the line recovers so a stuck-low rx cannot retrigger
        cnt_cyc_nxt = '0;
        if (rx_p1) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        cnt_cyc_nxt = '0;
        cnt_bit_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected pulses, a monitor
// pops and compares them whenever rx_valid or rx_frame_err fires.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int PER = 434;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  typedef struct {
    bit         err;
    logic [7:0] data;
    longint     t0;
    bit         chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   prev_pulse = 1'b0;

  uart_rx dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit err, input logic [7:0] data, input bit chk_lat);
    exp_t e;
    e.err = err;
    e.data = data;
    e.t0 = longint'($time);
    e.chk_lat = chk_lat;
    exp_q.push_back(e);
  endtask

  // stop_low drives the stop bit low and keeps the line low for 3 more bit times
  task automatic send_frame(input logic [7:0] b, input int per, input int nstop, input bit stop_low);
    rx = 1'b0;
    repeat (per) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(posedge sys_clk);
    end
    if (stop_low) begin
      rx = 1'b0;
      repeat (per * 4) @(posedge sys_clk);
    end else begin
      rx = 1'b1;
      repeat (per * nstop) @(posedge sys_clk);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_frame_err"}, rx_frame_err, 0);
    check({tag, "_rx_busy"}, rx_busy, 0);
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (rx_valid || rx_frame_err) begin
        check("pulse_exclusive", rx_valid & rx_frame_err, 0);
        check("pulse_single_cycle", prev_pulse, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {rx_valid, rx_frame_err}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind_frame_err", rx_frame_err, e.err);
          check("rx_data", rx_data, e.data);
          if (e.chk_lat) begin
            longint lat;
            lat = (longint'($time) - e.t0 - 5) / 10;
            total++;
            if (lat < 4119 || lat > 4127) begin
              bad++;
              $display("FAIL latency: got %0d cycles expected 4119..4127", lat);
            end
          end
        end
      end
      prev_pulse = rx_valid | rx_frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    int busy_cnt;

    repeat (5) @(posedge sys_clk);
    #1 check_outputs_zero("reset");
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1 check_outputs_zero("post_reset");

    // 0x55 with latency check
    @(posedge sys_clk);
    push(1'b0, 8'h55, 1'b1);
    send_frame(8'h55, PER, 2, 1'b0);
    repeat (PER) @(posedge sys_clk);

    // back-to-back with 2 stop bits, then with 1 stop bit
    push(1'b0, 8'hA3, 1'b0);
    send_frame(8'hA3, PER, 2, 1'b0);
    push(1'b0, 8'h0F, 1'b0);
    send_frame(8'h0F, PER, 2, 1'b0);
    push(1'b0, 8'hA3, 1'b0);
    send_frame(8'hA3, PER, 1, 1'b0);
    push(1'b0, 8'h0F, 1'b0);
    send_frame(8'h0F, PER, 1, 1'b0);
    repeat (PER) @(posedge sys_clk);

    // 100-cycle low glitch
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 100) rx = 1'b1;
      @(posedge sys_clk);
      #1 if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_len_ok", (busy_cnt > 0 && busy_cnt <= PER / 2 + 4), 1);
    check("glitch_busy_after", rx_busy, 0);
    push(1'b0, 8'h3C, 1'b0);
    send_frame(8'h3C, PER, 2, 1'b0);
    repeat (PER) @(posedge sys_clk);

    // framing error, line held low, rx_data must keep 0x3C
    push(1'b1, 8'h3C, 1'b0);
    send_frame(8'hFF, PER, 2, 1'b1);
    #1 check("break_busy_while_low", rx_busy, 1);
    rx = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1 check("break_busy_after_high", rx_busy, 0);
    check("break_rx_data_kept", rx_data, 8'h3C);
    repeat (PER) @(posedge sys_clk);
    push(1'b0, 8'h81, 1'b0);
    send_frame(8'h81, PER, 2, 1'b0);
    repeat (PER) @(posedge sys_clk);

    // reset during data bit 4 of 0xC6
    rx = 1'b0;
    repeat (PER) @(posedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rx = 8'hC6 >> i;
      repeat (PER) @(posedge sys_clk);
    end
    rx = 1'b0;
    repeat (PER / 2) @(posedge sys_clk);
    sys_rst_n = 1'b0;
    #1 check_outputs_zero("midframe_reset");
    rx = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1 check_outputs_zero("midframe_reset_held");
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (PER * 2) @(posedge sys_clk);
    #1 check_outputs_zero("after_abort");
    @(posedge sys_clk);
    push(1'b0, 8'h5A, 1'b0);
    send_frame(8'h5A, PER, 2, 1'b0);
    repeat (PER) @(posedge sys_clk);

    // transmitter baud error of about -2% and +2%
    push(1'b0, 8'h96, 1'b0);
    send_frame(8'h96, 425, 2, 1'b0);
    repeat (PER) @(posedge sys_clk);
    push(1'b0, 8'h96, 1'b0);
    send_frame(8'h96, 443, 2, 1'b0);

    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge sys_clk);
    repeat (PER) @(posedge sys_clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_rx_data", rx_data, 8'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
